hvac_sequencer: RTL and testbench

HVAC_SEQUENCER -- requirements
Module: hvac_sequencer

---
 rtl/hvac_sequencer.sv | 113 +++++++++++
 tb/tb_hvac_sequencer.sv | 111 +++++++++++
 2 files changed

// File: rtl/hvac_sequencer.sv
// Heat/cool sequencer: hysteresis thresholds, minimum run/off dwell, fixed fan purge
// after every run, and saturating start counters.
module hvac_sequencer #(
  parameter int unsigned HEAT_ON   = 18,
  parameter int unsigned HEAT_OFF  = 20,
  parameter int unsigned COOL_ON   = 22,
  parameter int unsigned COOL_OFF  = 20,
  parameter int unsigned MIN_RUN   = 4,
  parameter int unsigned MIN_OFF   = 6,
  parameter int unsigned FAN_PURGE = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [4:0] temperature,
  input  logic       sensor_valid,
  output logic       heating,
  output logic       cooling,
  output logic       fan,
  output logic [1:0] state,
  output logic [7:0] heat_starts,
  output logic [7:0] cool_starts
);

  localparam int unsigned MAX_A = (MIN_RUN > MIN_OFF) ? MIN_RUN : MIN_OFF;
  localparam int unsigned MAX_D = (MAX_A > FAN_PURGE) ? MAX_A : FAN_PURGE;
  localparam int unsigned CW    = (MAX_D < 2) ? 1 : $clog2(MAX_D + 1);

  localparam logic [4:0]    HEAT_ON_T  = 5'(HEAT_ON);
  localparam logic [4:0]    HEAT_OFF_T = 5'(HEAT_OFF);
  localparam logic [4:0]    COOL_ON_T  = 5'(COOL_ON);
  localparam logic [4:0]    COOL_OFF_T = 5'(COOL_OFF);
  localparam logic [CW-1:0] RUN_LAST   = CW'(MIN_RUN - 1);
  localparam logic [CW-1:0] OFF_LAST   = CW'(MIN_OFF - 1);
  localparam logic [CW-1:0] PURGE_LAST = CW'(FAN_PURGE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    HEAT  = 2'b01,
    COOL  = 2'b10,
    PURGE = 2'b11
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    hs_q, hs_d;
  logic [7:0]    cs_q, cs_d;
  logic          heat_q, cool_q, fan_q;

  logic want_heat, want_cool, heat_done, cool_done, start_ok, run_done;

  assign want_heat = sensor_valid && (temperature <  HEAT_ON_T);
  assign want_cool = sensor_valid && (temperature >  COOL_ON_T);
  assign heat_done = sensor_valid && (temperature >= HEAT_OFF_T);
  assign cool_done = sensor_valid && (temperature <= COOL_OFF_T);
  // Reset loads cnt with all-ones, so IDLE entered from reset already permits a start.
  assign start_ok  = (cnt_q >= OFF_LAST);
  assign run_done  = (cnt_q >= RUN_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (enable && start_ok && want_heat)      state_d = HEAT;
        else if (enable && start_ok && want_cool) state_d = COOL;
      end
      HEAT:  if (!enable || (run_done && heat_done)) state_d = PURGE;
      COOL:  if (!enable || (run_done && cool_done)) state_d = PURGE;
      PURGE: if (cnt_q == PURGE_LAST)                state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    hs_d  = hs_q;
    cs_d  = cs_q;
    if (state_d != state_q) cnt_d = '0;
    else if (cnt_q != '1)   cnt_d = cnt_q + CW'(1);
    if (state_q == IDLE && state_d == HEAT && hs_q != '1) hs_d = hs_q + 8'd1;
    if (state_q == IDLE && state_d == COOL && cs_q != '1) cs_d = cs_q + 8'd1;
  end

  // Actuator drives are flops loaded from the decoded next state, so they match
  // the state register exactly and never glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '1;
      hs_q    <= '0;
      cs_q    <= '0;
      heat_q  <= 1'b0;
      cool_q  <= 1'b0;
      fan_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hs_q    <= hs_d;
      cs_q    <= cs_d;
      heat_q  <= (state_d == HEAT);
      cool_q  <= (state_d == COOL);
      fan_q   <= (state_d != IDLE);
    end
  end

  assign state       = state_q;
  assign heating     = heat_q;
  assign cooling     = cool_q;
  assign fan         = fan_q;
  assign heat_starts = hs_q;
  assign cool_starts = cs_q;

endmodule

// File: tb/tb_hvac_sequencer.sv
// Directed bench for hvac_sequencer: expected output vectors are queued as each
// step is driven and popped for comparison one edge later.
module tb_hvac_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [4:0] temperature = '0;
  logic       sensor_valid = 1'b0;
  logic       heating, cooling, fan;
  logic [1:0] state;
  logic [7:0] heat_starts, cool_starts;

  localparam logic [1:0] S_IDLE = 2'b00, S_HEAT = 2'b01, S_COOL = 2'b10, S_PURGE = 2'b11;

  hvac_sequencer #(
    .HEAT_ON(18), .HEAT_OFF(20), .COOL_ON(22), .COOL_OFF(20),
    .MIN_RUN(4), .MIN_OFF(6), .FAN_PURGE(3)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .temperature(temperature),
    .sensor_valid(sensor_valid), .heating(heating), .cooling(cooling), .fan(fan),
    .state(state), .heat_starts(heat_starts), .cool_starts(cool_starts)
  );

  always #5 clk = ~clk;

  logic [20:0] exp_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned hs = 0;
  int unsigned cs = 0;

  task automatic step(input bit r, input bit e, input bit v, input logic [4:0] t,
                      input logic [1:0] es, input string tag);
    logic [20:0] got, exp;
    rst = r; enable = e; sensor_valid = v; temperature = t;
    exp_q.push_back({es, es == S_HEAT, es == S_COOL, es != S_IDLE, 8'(hs), 8'(cs)});
    @(posedge clk);
    #1;
    got = {state, heating, cooling, fan, heat_starts, cool_starts};
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL %s scoreboard empty observed=%h", tag, got);
    end else begin
      exp = exp_q.pop_front();
      assert (got === exp) else begin
        n_err++;
        $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
    end
  endtask

  initial begin
    @(posedge clk); #1;
    step(1, 1, 1, 5'd17, S_IDLE, "reset");

    hs = 1;
    step(0, 1, 1, 5'd17, S_HEAT, "heat_from_reset");
    for (int i = 0; i < 3; i++) step(0, 1, 1, 5'd21, S_HEAT, "heat_minrun");
    step(0, 1, 1, 5'd21, S_PURGE, "heat_to_purge");
    for (int i = 0; i < 2; i++) step(0, 1, 1, 5'd21, S_PURGE, "purge_hold");
    step(0, 1, 1, 5'd21, S_IDLE, "purge_to_idle");

    for (int i = 0; i < 5; i++) step(0, 1, 1, 5'd25, S_IDLE, "min_off_hold");
    cs = 1;
    step(0, 1, 1, 5'd25, S_COOL, "cool_start");
    step(0, 1, 1, 5'd25, S_COOL, "cool_cnt1");
    step(0, 0, 1, 5'd25, S_PURGE, "cool_enable_off");
    for (int i = 0; i < 2; i++) step(0, 0, 1, 5'd25, S_PURGE, "purge_disabled");
    step(0, 0, 1, 5'd25, S_IDLE, "purge_exit_disabled");

    for (int i = 0; i < 6; i++) step(0, 0, 1, 5'd17, S_IDLE, "idle_disabled");
    hs = 2;
    step(0, 1, 1, 5'd17, S_HEAT, "heat_start2");
    for (int i = 0; i < 5; i++) step(0, 1, 1, 5'd19, S_HEAT, "heat_band");
    step(0, 1, 0, 5'd20, S_HEAT, "heat_invalid_off");
    step(0, 1, 1, 5'd20, S_PURGE, "heat_off_at_20");
    for (int i = 0; i < 2; i++) step(0, 1, 1, 5'd20, S_PURGE, "purge_hold2");
    step(0, 1, 1, 5'd20, S_IDLE, "purge_to_idle2");

    for (int i = 0; i < 7; i++) step(0, 1, 0, 5'd5, S_IDLE, "idle_invalid_cold");
    step(0, 1, 1, 5'd18, S_IDLE, "idle_at_heat_on");
    step(0, 1, 1, 5'd22, S_IDLE, "idle_at_cool_on");
    cs = 2;
    step(0, 1, 1, 5'd23, S_COOL, "cool_start2");
    for (int i = 0; i < 5; i++) step(0, 1, 1, 5'd21, S_COOL, "cool_band");

    hs = 0; cs = 0;
    step(1, 1, 1, 5'd21, S_IDLE, "reset_mid_cool");
    hs = 1;
    step(0, 1, 1, 5'd17, S_HEAT, "heat_after_reset");
    step(0, 0, 1, 5'd17, S_PURGE, "heat_enable_off");
    for (int i = 0; i < 2; i++) step(0, 0, 1, 5'd17, S_PURGE, "purge_hold3");
    step(0, 0, 1, 5'd17, S_IDLE, "purge_to_idle3");
    for (int i = 0; i < 5; i++) step(0, 0, 1, 5'd17, S_IDLE, "idle_wait");

    for (int n = 0; n < 258; n++) begin
      if (hs < 255) hs++;
      step(0, 1, 1, 5'd17, S_HEAT, "sat_heat");
      step(0, 0, 1, 5'd17, S_PURGE, "sat_purge");
      for (int i = 0; i < 2; i++) step(0, 0, 1, 5'd17, S_PURGE, "sat_purge_hold");
      step(0, 0, 1, 5'd17, S_IDLE, "sat_idle");
      for (int i = 0; i < 5; i++) step(0, 0, 1, 5'd17, S_IDLE, "sat_idle_wait");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
